stream_arb_mux: RTL and testbench
=================================

Name: stream_arb_mux

Overview:
- Parametrised N:1 stream multiplexer with built-in arbitration; next generation of the plain combinational word mux.
- Each input channel carries valid/ready/last. The block selects one channel per burst, using either fixed-priority or round-robin arbitration.
- It forwards the selected beats through a single registered output stage.
- Used wherever several producers (e.g. memory-mapped peripherals, debug taps) share one 32-bit consumer port.

Parameters:
- WIDTH, 32: data width per channel.
- SELW, 3: select width; channel count NCH = 2**SELW (default 8).
- RR, 1: 1 = round-robin arbitration; 0 = fixed priority, lowest index wins.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_data  in  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  in  NCH  per-channel beat valid
- in_last  in  NCH  per-channel end-of-burst marker
- in_ready  out  NCH  per-channel accept; at most one bit high
- out_data  out  WIDTH  registered data
- out_valid  out  1  registered valid
- out_last  out  1  registered last
- out_sel  out  SELW  channel index of the beat in the output register
- out_ready  in  1  consumer accept

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clk, rst_n). While rst_n = 0, the following are all 0:
  - out_valid, out_data, out_last, out_sel
  - state = IDLE, grant = 0, rr pointer = 0
  - in_ready
- Reset mid-burst: the held beat and the lock are discarded. There is no recovery handshake.
- can_load = !out_valid | out_ready.
- States: IDLE, LOCKED.
- IDLE:
  - Winner = first set in_valid bit, scanning from ptr upward with wrap NCH-1 -> 0. With RR=0, ptr is fixed at 0.
  - in_ready[winner] = can_load; all other bits 0. No valid input: in_ready = 0 and the state holds.
  - On transfer (in_valid[w] & in_ready[w]):
    - the output register loads data, last and sel = w;
    - if in_last[w] = 0: go to LOCKED with grant = w;
    - if in_last[w] = 1: stay in IDLE, and ptr <= w+1 (mod NCH) when RR=1.
- LOCKED:
  - Only the grant channel is eligible; in_ready[grant] = can_load.
  - Other channels wait regardless of their valid.
  - On a transfer with in_last = 1: return to IDLE, and ptr <= grant+1 (mod NCH) when RR=1.
  - Transfers with in_last = 0 stay in LOCKED.
- Latency: a beat accepted on edge k appears with out_valid = 1 after edge k.
- Throughput: one beat per cycle when out_ready is held high. A simultaneous drain and load in the same cycle is legal and required.
- Output stability: while out_valid & !out_ready, out_data, out_last and out_sel hold constant.
- Idle output: out_valid falls to 0 after the consumer takes the beat if no new beat is loaded.
- in_ready depends combinationally on in_valid, state, ptr, out_valid and out_ready. It never depends on in_data.
- Arbitration happens only at burst boundaries. A channel that drops in_valid mid-burst stalls the mux; the lock is kept.
- NCH = 2 (SELW=1) and SELW up to 5 must elaborate. Index arithmetic is SELW bits wide and wraps naturally.

Test Plan:
- Single beat: reset, then ch3 valid=1, last=1, data=32'hDEADBEEF, out_ready=1 -> in_ready=8'h08 that cycle. Next cycle out_valid=1, out_data=DEADBEEF, out_sel=3, out_last=1; ptr=4.
- Round-robin fairness: RR=1, all 8 channels valid with single-beat bursts, out_ready=1 -> out_sel sequence 0,1,...,7,0 with one beat per cycle and no bubbles.
- Fixed priority: RR=0, channels 2 and 5 both continuously valid with single beats -> every beat has out_sel=2; channel 5 is never granted.
- Burst lock: ch1 sends a 4-beat burst (last on beat 4) while ch0 is valid throughout -> four consecutive beats with out_sel=1 and no ch0 beats interleaved. With RR=1, ch0 wins next only after ch2-ch7 are scanned (ptr=2); ch0 is the winner if ch2-ch7 are idle.
- Backpressure: out_ready=0 for 5 cycles with ch6 holding a beat -> out_data stable, in_ready=0 for all channels. On out_ready=1 the held beat drains and the next beat loads in the same cycle.
- Async reset mid-burst: drop rst_n between edges during LOCKED on ch4 -> out_valid and in_ready go 0 immediately, without waiting for a clock edge. After release, the next arbitration starts at ptr=0 in IDLE.

Source files
------------

// File: rtl/stream_arb_mux.sv
// N:1 stream multiplexer with burst-locked arbitration (round-robin or fixed priority)
// and a single registered output stage that supports simultaneous drain and load.
module stream_arb_mux #(
  parameter int WIDTH = 32,
  parameter int SELW  = 3,
  parameter bit RR    = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [(2**SELW)*WIDTH-1:0]    in_data,
  input  logic [(2**SELW)-1:0]          in_valid,
  input  logic [(2**SELW)-1:0]          in_last,
  output logic [(2**SELW)-1:0]          in_ready,
  output logic [WIDTH-1:0]              out_data,
  output logic                          out_valid,
  output logic                          out_last,
  output logic [SELW-1:0]               out_sel,
  input  logic                          out_ready
);

  localparam int NCH = 2**SELW;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t           r_state, w_state_nxt;
  logic [SELW-1:0]  r_grant, w_grant_nxt;
  logic [SELW-1:0]  r_ptr, w_ptr_nxt;
  logic [SELW-1:0]  w_win, w_idx, w_sel, w_sel_inc;
  logic             w_found, w_can_load, w_elig, w_xfer;
  logic [WIDTH-1:0] w_mux_data;

  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;
  logic             r_out_last;
  logic [SELW-1:0]  r_out_sel;

  // Scan from the pointer upward; SELW-bit addition gives the wrap NCH-1 -> 0.
  always_comb begin
    w_win   = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      w_idx = r_ptr + SELW'(i);
      if (!w_found && in_valid[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  always_comb begin
    w_can_load  = !r_out_valid || out_ready;
    w_sel       = (r_state == LOCKED) ? r_grant : w_win;
    w_elig      = (r_state == LOCKED) || w_found;
    w_sel_inc   = w_sel + 1'b1;
    w_mux_data  = in_data[w_sel*WIDTH +: WIDTH];

    // Gated by rst_n so no channel is accepted while reset is held.
    in_ready = '0;
    if (rst_n && w_elig && w_can_load) begin
      in_ready[w_sel] = 1'b1;
    end
    w_xfer = in_valid[w_sel] && in_ready[w_sel];

    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_ptr_nxt   = r_ptr;
    if (w_xfer) begin
      if (in_last[w_sel]) begin
        w_state_nxt = IDLE;
        if (RR) begin
          w_ptr_nxt = w_sel_inc;
        end
      end else begin
        w_state_nxt = LOCKED;
        w_grant_nxt = w_sel;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_grant     <= '0;
      r_ptr       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_sel   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_ptr   <= w_ptr_nxt;
      if (w_xfer) begin
        r_out_data  <= w_mux_data;
        r_out_valid <= 1'b1;
        r_out_last  <= in_last[w_sel];
        r_out_sel   <= w_sel;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_stream_arb_mux.sv
// Scoreboard bench for stream_arb_mux: a round-robin instance and a fixed-priority instance,
// directed stimulus pushes expected beats, negedge monitors pop and compare.
module tb_stream_arb_mux;

  localparam int W = 32;
  localparam int S = 3;
  localparam int N = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N*W-1:0] in_data_a, in_data_b;
  logic [N-1:0]   in_valid_a, in_last_a, in_ready_a;
  logic [N-1:0]   in_valid_b, in_last_b, in_ready_b;
  logic [W-1:0]   out_data_a, out_data_b;
  logic           out_valid_a, out_last_a, out_ready_a;
  logic           out_valid_b, out_last_b, out_ready_b;
  logic [S-1:0]   out_sel_a, out_sel_b;

  stream_arb_mux #(.WIDTH(W), .SELW(S), .RR(1'b1)) u_rr (
    .clk(clk), .rst_n(rst_n), .in_data(in_data_a), .in_valid(in_valid_a),
    .in_last(in_last_a), .in_ready(in_ready_a), .out_data(out_data_a),
    .out_valid(out_valid_a), .out_last(out_last_a), .out_sel(out_sel_a),
    .out_ready(out_ready_a));

  stream_arb_mux #(.WIDTH(W), .SELW(S), .RR(1'b0)) u_fp (
    .clk(clk), .rst_n(rst_n), .in_data(in_data_b), .in_valid(in_valid_b),
    .in_last(in_last_b), .in_ready(in_ready_b), .out_data(out_data_b),
    .out_valid(out_valid_b), .out_last(out_last_b), .out_sel(out_sel_b),
    .out_ready(out_ready_b));

  typedef struct packed {
    logic [31:0] d;
    logic        l;
    logic [2:0]  s;
  } beat_t;

  beat_t qa[$];
  beat_t qb[$];
  beat_t ea, eb;
  int nchk = 0;
  int nfail = 0;

  int rem[N];
  int blen[N];
  int sent[N];
  bit feed_en = 1'b0;

  function automatic logic [31:0] bdat(input int ch, input int n);
    return {4'hC, 4'(ch), 8'h00, 16'(n)};
  endfunction

  function automatic beat_t mk(input int ch, input int n, input logic l);
    beat_t b;
    b.d = bdat(ch, n);
    b.l = l;
    b.s = 3'(ch);
    return b;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid_a && out_ready_a) begin
      if (qa.size() == 0) begin
        nchk++;
        nfail++;
        $display("FAIL A beat: got %h expected none", {out_data_a, out_last_a, out_sel_a});
      end else begin
        ea = qa.pop_front();
        chk("A beat", {out_data_a, out_last_a, out_sel_a}, ea);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && out_valid_b && out_ready_b) begin
      if (qb.size() == 0) begin
        nchk++;
        nfail++;
        $display("FAIL B beat: got %h expected none", {out_data_b, out_last_b, out_sel_b});
      end else begin
        eb = qb.pop_front();
        chk("B beat", {out_data_b, out_last_b, out_sel_b}, eb);
      end
    end
  end

  // Per-channel producer for instance A: presents beat 'sent' until accepted.
  initial begin
    logic [N-1:0] hs;
    forever begin
      @(negedge clk);
      hs = in_valid_a & in_ready_a;
      @(posedge clk);
      #1;
      if (feed_en) begin
        for (int c = 0; c < N; c++) begin
          if (hs[c]) begin
            sent[c]++;
            rem[c]--;
          end
          in_valid_a[c] = (rem[c] > 0);
          in_last_a[c]  = ((sent[c] + 1) % blen[c]) == 0;
          in_data_a[c*W +: W] = bdat(c, sent[c]);
        end
      end
    end
  end

  task automatic setup();
    for (int c = 0; c < N; c++) begin
      rem[c]  = 0;
      sent[c] = 0;
      blen[c] = 1;
    end
  endtask

  task automatic drain(input string nm);
    int t = 0;
    while (qa.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk(nm, 64'(qa.size()), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic run_len(input string nm, input int exp_n);
    int t = 0;
    int n = 0;
    @(negedge clk);
    while (!out_valid_a && t < 20) begin
      @(negedge clk);
      t++;
    end
    while (out_valid_a && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk(nm, 64'(n), 64'(exp_n));
  endtask

  task automatic wait_valid_a(input string nm);
    int t = 0;
    @(negedge clk);
    while (!out_valid_a && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk(nm, 64'(out_valid_a), 64'd1);
  endtask

  task automatic do_reset();
    feed_en    = 1'b0;
    in_valid_a = '0;
    in_last_a  = '0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int t;
    in_data_a = '0; in_valid_a = '1; in_last_a = '0; out_ready_a = 1'b0;
    in_data_b = '0; in_valid_b = '0; in_last_b = '0; out_ready_b = 1'b0;
    setup();
    #1;
    chk("reset out_valid", 64'(out_valid_a), 64'd0);
    chk("reset out_data", 64'(out_data_a), 64'd0);
    chk("reset out_sel/last", 64'({out_sel_a, out_last_a}), 64'd0);
    chk("reset in_ready", 64'(in_ready_a), 64'd0);
    chk("reset B out_valid", 64'(out_valid_b), 64'd0);
    in_valid_a = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Single beat on ch3
    @(posedge clk);
    #1;
    in_data_a[3*W +: W] = 32'hDEADBEEF;
    in_valid_a = 8'h08;
    in_last_a  = 8'h08;
    out_ready_a = 1'b1;
    qa.push_back({32'hDEADBEEF, 1'b1, 3'd3});
    #1;
    chk("single in_ready", 64'(in_ready_a), 64'h08);
    @(posedge clk);
    #1;
    in_valid_a = '0;
    in_last_a  = '0;
    drain("single drain");

    // Pointer now 4: ch5 wins over ch2, then ch2
    setup();
    rem[2] = 1;
    rem[5] = 1;
    qa.push_back(mk(5, 0, 1'b1));
    qa.push_back(mk(2, 0, 1'b1));
    feed_en = 1'b1;
    drain("ptr4 drain");

    // Round-robin fairness from pointer 0
    do_reset();
    setup();
    for (int c = 0; c < N; c++) rem[c] = 1;
    rem[0] = 2;
    for (int c = 0; c < N; c++) qa.push_back(mk(c, 0, 1'b1));
    qa.push_back(mk(0, 1, 1'b1));
    feed_en = 1'b1;
    run_len("rr no-bubble run", 9);
    drain("rr drain");

    // Burst lock: ch1 4-beat burst while ch0 waits (pointer is 1)
    setup();
    rem[1] = 4; blen[1] = 4;
    rem[0] = 1;
    qa.push_back(mk(1, 0, 1'b0));
    qa.push_back(mk(1, 1, 1'b0));
    qa.push_back(mk(1, 2, 1'b0));
    qa.push_back(mk(1, 3, 1'b1));
    qa.push_back(mk(0, 0, 1'b1));
    feed_en = 1'b1;
    run_len("burst run", 5);
    drain("burst drain");

    // Backpressure on ch6
    out_ready_a = 1'b0;
    setup();
    rem[6] = 2;
    qa.push_back(mk(6, 0, 1'b1));
    qa.push_back(mk(6, 1, 1'b1));
    feed_en = 1'b1;
    wait_valid_a("bp first valid");
    for (int i = 0; i < 5; i++) begin
      chk("bp hold data", 64'(out_data_a), 64'(bdat(6, 0)));
      chk("bp in_ready", 64'(in_ready_a), 64'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    out_ready_a = 1'b1;
    @(negedge clk);
    chk("bp release in_ready", 64'(in_ready_a), 64'h40);
    @(negedge clk);
    chk("bp reload", 64'({out_valid_a, out_data_a}), 64'({1'b1, bdat(6, 1)}));
    drain("bp drain");

    // Async reset while locked on ch4
    out_ready_a = 1'b0;
    setup();
    rem[4] = 2; blen[4] = 4;
    feed_en = 1'b1;
    wait_valid_a("lock first valid");
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst out_valid", 64'(out_valid_a), 64'd0);
    chk("async rst in_ready", 64'(in_ready_a), 64'd0);
    feed_en = 1'b0;
    in_valid_a = '0;
    in_last_a  = '0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready_a = 1'b1;
    setup();
    rem[1] = 1;
    rem[7] = 1;
    qa.push_back(mk(1, 0, 1'b1));
    qa.push_back(mk(7, 0, 1'b1));
    feed_en = 1'b1;
    drain("post-reset drain");

    // Fixed priority instance: ch2 always beats ch5
    in_data_b[2*W +: W] = 32'h2222_2222;
    in_data_b[5*W +: W] = 32'h5555_5555;
    in_valid_b  = 8'h24;
    in_last_b   = 8'h24;
    out_ready_b = 1'b1;
    for (int i = 0; i < 6; i++) qb.push_back({32'h2222_2222, 1'b1, 3'd2});
    @(negedge clk);
    chk("fp in_ready", 64'(in_ready_b), 64'h04);
    t = 0;
    while (qb.size() != 0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    #1;
    in_valid_b  = '0;
    out_ready_b = 1'b0;
    chk("fp drain", 64'(qb.size()), 64'd0);

    repeat (3) @(negedge clk);
    chk("A queue empty", 64'(qa.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
